sdm_sched: RTL and testbench
============================

# sdm_sched

Round-robin scheduler that shares one `sdm_tx` sigma-delta serializer between `NCH` sample requesters.
- Each requester offers signed 4-bit samples over a valid/ready handshake.
- The block grants one requester at a time and drives the serializer's `push`/`wdata`/`clear` handshake.
- It supervises completion through `empty` and recovers from a stalled serializer with a timeout-driven clear.
- It sits between sample producers (per-channel DSP or register front-ends) and the `sdm_tx` instance.

## Interface
Parameters:
- `NCH`, 4: number of requesters, 2..8.
- `IDW`, 2: grant-id width, equal to ceil(log2(NCH)), minimum 1.
- `TMO`, 255: cycle limit for any serializer wait state, 1..65535.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  reset, synchronous and active-high.
- `enable`  in  1  scheduler run enable.
- `req_valid`  in  NCH  per-requester sample valid.
- `req_data`  in  4*NCH  signed samples; requester i occupies bits [4i+3:4i].
- `req_ready`  out  NCH  one-hot, one-cycle accept pulse.
- `tx_empty`  in  1  serializer `empty`.
- `tx_push`  out  1  serializer `push`.
- `tx_clear`  out  1  serializer `clear`.
- `tx_wdata`  out  4  signed sample to the serializer.
- `grant_id`  out  IDW  index of the requester currently served.
- `busy`  out  1  high in every state except IDLE.
- `tmo_err`  out  1  sticky timeout flag, cleared by `rst` or by `enable` low.

## Operation
- FSM states:
  - IDLE: waits for `enable` high and `tx_empty` high, then goes to ARB.
  - ARB: round-robin pick. The search starts at `last+1` mod NCH and takes the first requester with `req_valid` set.
    - If a requester is found, the block latches its sample into `tx_wdata`, latches its index into `grant_id`, pulses `req_ready[i]`, updates `last`, and goes to PUSH.
    - If none is found, it stays in ARB. `enable` low returns it to IDLE.
  - PUSH: `tx_push` is held high until `tx_empty` goes low (serializer accepted), then the block goes to DRAIN.
  - DRAIN: `tx_push` is low. The block waits for `tx_empty` high, then returns to ARB, or to IDLE if `enable` is low.
  - ABORT: `tx_clear` is high for exactly one cycle, `tmo_err` is set, and the block goes to IDLE.
- Timeout:
  - A wait counter clears on entry to PUSH and on entry to DRAIN, and increments every cycle spent in those states.
  - When the counter reaches `TMO`, the block goes to ABORT.
- `enable` dropping during PUSH or DRAIN does not abort. The current sample completes first.
- `req_data` is sampled only in ARB. Later changes do not affect `tx_wdata`.
- Width rule: `tx_wdata` is passed through unmodified. The value -8 (4'b1000) is legal.
- Reset values:
  - state IDLE; `last` = NCH-1, so requester 0 has first priority.
  - `req_ready` = 0, `tx_push` = 0, `tx_clear` = 0.
  - `tx_wdata` = 0, `grant_id` = 0, `busy` = 0, `tmo_err` = 0.

## Timing
- `req_valid[i]` high while in ARB: `req_ready[i]` pulses in that same cycle, and `tx_push` rises on the next cycle.
- Push handshake:
  - `tx_push` stays high for at least 1 cycle.
  - It falls in the cycle after `tx_empty` is sampled low.
- Back-to-back throughput: one sample per serializer frame plus 2 cycles (DRAIN→ARB, ARB→PUSH).
- `tmo_err` rises in the ABORT cycle, together with `tx_clear`.
- `rst` takes effect on the next `clk` edge and overrides every other input, including mid-PUSH. After reset `tx_push` is low and no `req_ready` pulse occurs.
- Simultaneous valids: exactly one grant per ARB cycle, in rotating order. A continuously valid requester waits at most NCH-1 grants.

## Configuration
- `SDM_SCHED_IDLE_FILL_EN` defined:
  - If ARB finds no valid requester while `enable` is high, the block pushes sample 0 (the zero-mean pattern) without pulsing any `req_ready`.
  - `grant_id` holds its previous value and `last` is not updated.
  - This keeps the modulator output continuous.
- `SDM_SCHED_IDLE_FILL_EN` undefined: ARB idles with `tx_push` low when no requester is valid.

## Test plan
- Single requester: `rst`; `enable`=1; `req_valid`=4'b0100, `req_data[11:8]`=4'sd5; serializer model drops `empty` 1 cycle after push and raises it 16 cycles later. Required: `req_ready`=4'b0100 once, `tx_wdata`=5, `grant_id`=2, one push, back to ARB.
- Fairness: all four valid continuously with data 1,2,3,4. Required: grant order 0,1,2,3,0 and `tx_wdata` sequence 1,2,3,4,1.
- Timeout: `TMO`=8 and `tx_empty` stuck high after push. Required: ABORT 8 cycles into PUSH, `tx_clear` high for 1 cycle, `tmo_err`=1, IDLE. Then `enable`=0 clears `tmo_err`.
- Edge values: `req_data`=-8 passes as `tx_wdata`=4'b1000. `enable` dropped mid-DRAIN: the frame completes, then IDLE with `busy`=0.
- Reset mid-PUSH: `rst` asserted while `tx_push`=1. Required: next cycle all outputs at reset values, and the next grant goes to requester 0.
- Idle fill, with the macro defined: `enable`=1 and no valids. Required: `tx_push` pulses with `tx_wdata`=0 each frame, `req_ready` stays 0. Without the macro: `tx_push` stays 0.

Source files
------------

// File: rtl/sdm_sched.sv
// sdm_sched: round-robin scheduler sharing one sdm_tx sigma-delta serializer
// between NCH signed 4-bit sample requesters.
//
// Optional feature macro: SDM_SCHED_IDLE_FILL_EN
//   defined   -> ARB with enable high and no valid requester pushes sample 0
//                (zero-mean fill) without pulsing any ready or moving grant_id.
//   undefined -> ARB idles with tx_push low when nothing is valid.
//
// Outputs are decoded from the state and registered datapath only, so none of
// them depend combinationally on i_tx_empty. o_req_ready depends on
// i_req_valid in ARB, which gives the same-cycle accept pulse.

module sdm_sched #(
  parameter int NCH = 4,    // requesters, 2..8
  parameter int IDW = 2,    // ceil(log2(NCH)), minimum 1
  parameter int TMO = 255   // wait-state cycle limit, 1..65535
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic [NCH-1:0]   i_req_valid,
  input  logic [4*NCH-1:0] i_req_data,
  output logic [NCH-1:0]   o_req_ready,
  input  logic             i_tx_empty,
  output logic             o_tx_push,
  output logic             o_tx_clear,
  output logic [3:0]       o_tx_wdata,
  output logic [IDW-1:0]   o_grant_id,
  output logic             o_busy,
  output logic             o_tmo_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_PUSH,
    S_DRAIN,
    S_ABORT
  } state_t;

  // The wait counter stops at TMO-1: reaching TMO and leaving happen together.
  localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

  state_t         r_state;
  state_t         w_next;
  logic [IDW-1:0] r_last;
  logic [IDW-1:0] r_grant;
  logic [3:0]     r_wdata;
  logic [15:0]    r_cnt;
  logic           r_tmo_err;

  logic           w_found;
  logic [IDW-1:0] w_pick;
  logic [3:0]     w_pick_data;
  int             w_best;
  logic           w_grant;
  logic           w_fill;
  logic           w_tmo_hit;

  // Round-robin search: the valid requester closest after r_last wins.
  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that leaves
    // one unassigned would make synthesis infer a latch to hold its old value.
    w_found     = 1'b0;
    w_pick      = '0;
    w_pick_data = '0;
    w_best      = NCH;
    for (int i = 0; i < NCH; i++) begin
      // Distance from last+1 (mod NCH): 0 means "next in line".
      if (i_req_valid[i] && ((i + NCH - int'(r_last) - 1) % NCH) < w_best) begin
        w_best      = (i + NCH - int'(r_last) - 1) % NCH;
        w_found     = 1'b1;
        w_pick      = IDW'(i);
        w_pick_data = i_req_data[4*i +: 4];
      end
    end
  end

  assign w_tmo_hit = (r_cnt == TMO_LAST);

  // Next-state decode plus the grant/fill strobes and the accept pulse.
  always_comb begin
    w_next      = r_state;
    w_grant     = 1'b0;
    w_fill      = 1'b0;
    o_req_ready = '0;
    case (r_state)
      S_IDLE: begin
        if (i_enable && i_tx_empty) w_next = S_ARB;
      end
      S_ARB: begin
        if (!i_enable) begin
          w_next = S_IDLE;
        end else if (w_found) begin
          w_next      = S_PUSH;
          w_grant     = 1'b1;
          o_req_ready = NCH'(1) << w_pick;
        end
`ifdef SDM_SCHED_IDLE_FILL_EN
        else begin
          // Nothing to serve: keep the modulator fed with the zero-mean word.
          w_next = S_PUSH;
          w_fill = 1'b1;
        end
`endif
      end
      S_PUSH: begin
        // Acceptance wins over a timeout landing in the same cycle.
        if (!i_tx_empty)    w_next = S_DRAIN;
        else if (w_tmo_hit) w_next = S_ABORT;
      end
      S_DRAIN: begin
        // enable is only consulted once the current frame has finished.
        if (i_tx_empty)     w_next = i_enable ? S_ARB : S_IDLE;
        else if (w_tmo_hit) w_next = S_ABORT;
      end
      S_ABORT: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    // NOTE: state uses non-blocking assignment so every flop samples the values
    // from before the edge, independent of block evaluation order.
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Grant datapath: sample, index and round-robin pointer latch only in ARB.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last  <= IDW'(NCH - 1);
      r_grant <= '0;
      r_wdata <= '0;
    end else if (w_grant) begin
      r_last  <= w_pick;
      r_grant <= w_pick;
      r_wdata <= w_pick_data;
    end else if (w_fill) begin
      r_wdata <= '0;
    end
  end

  // Wait counter: restarts on every state change, counts in PUSH and DRAIN.
  always_ff @(posedge i_clk) begin
    if (i_rst)                                     r_cnt <= '0;
    else if (w_next != r_state)                    r_cnt <= '0;
    else if (r_state == S_PUSH || r_state == S_DRAIN) r_cnt <= r_cnt + 16'd1;
  end

  // Sticky timeout flag: set on entry to ABORT, dropped by enable low.
  always_ff @(posedge i_clk) begin
    if (i_rst)                                        r_tmo_err <= 1'b0;
    else if (w_next == S_ABORT && r_state != S_ABORT) r_tmo_err <= 1'b1;
    else if (!i_enable)                               r_tmo_err <= 1'b0;
  end

  assign o_tx_push  = (r_state == S_PUSH);
  assign o_tx_clear = (r_state == S_ABORT);
  assign o_busy     = (r_state != S_IDLE);
  assign o_tx_wdata = r_wdata;
  assign o_grant_id = r_grant;
  assign o_tmo_err  = r_tmo_err;

endmodule

// File: tb/tb_sdm_sched.sv
// tb_sdm_sched: table-driven and randomized checks of sdm_sched against a
// behavioural serializer and a round-robin reference model. A second instance
// with TMO=8 sees a serializer whose empty flag never drops.

module tb_sdm_sched;

  localparam int NCH   = 4;
  localparam int FRAME = 16;
`ifdef SDM_SCHED_IDLE_FILL_EN
  localparam bit FILL_EXP = 1'b1;
`else
  localparam bit FILL_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic        tx_empty;

  logic [3:0]  req_ready;
  logic        tx_push, tx_clear, busy, tmo_err;
  logic [3:0]  tx_wdata;
  logic [1:0]  grant_id;

  logic        t2_empty;
  logic [3:0]  t2_ready;
  logic        t2_push, t2_clear, t2_busy, t2_tmo_err;
  logic [3:0]  t2_wdata;
  logic [1:0]  t2_grant;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  sdm_sched #(.NCH(NCH), .IDW(2), .TMO(255)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable),
    .i_req_valid(req_valid), .i_req_data(req_data), .o_req_ready(req_ready),
    .i_tx_empty(tx_empty), .o_tx_push(tx_push), .o_tx_clear(tx_clear),
    .o_tx_wdata(tx_wdata), .o_grant_id(grant_id), .o_busy(busy),
    .o_tmo_err(tmo_err)
  );

  sdm_sched #(.NCH(NCH), .IDW(2), .TMO(8)) u_dut_tmo (
    .i_clk(clk), .i_rst(rst), .i_enable(enable),
    .i_req_valid(req_valid), .i_req_data(req_data), .o_req_ready(t2_ready),
    .i_tx_empty(t2_empty), .o_tx_push(t2_push), .o_tx_clear(t2_clear),
    .o_tx_wdata(t2_wdata), .o_grant_id(t2_grant), .o_busy(t2_busy),
    .o_tmo_err(t2_tmo_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Serializer model: takes a push while empty, holds empty low for FRAME cycles.
  int fcnt = 0;
  initial begin
    tx_empty = 1'b1;
    t2_empty = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        tx_empty = 1'b1;
        fcnt     = 0;
      end else if (fcnt > 0) begin
        fcnt--;
        if (fcnt == 0) tx_empty = 1'b1;
      end else if (tx_push && tx_empty) begin
        tx_empty = 1'b0;
        fcnt     = FRAME;
      end
    end
  end

  // Reference rule: first valid requester at or after last+1, wrapping.
  function automatic int rr_pick(input int last, input logic [3:0] v);
    for (int k = 1; k <= NCH; k++) begin
      if (v[(last + k) % NCH]) return (last + k) % NCH;
    end
    return -1;
  endfunction

  // Offer a request pattern, wait for the accept, check the push and its data.
  task automatic serve(input logic [3:0] v, input logic [15:0] d, input int exp_g,
                       input logic [3:0] exp_d, input string tag);
    int n;
    req_valid = v;
    req_data  = d;
    #1;
    n = 0;
    while (!(|req_ready) && n < 64) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 32'(req_ready), 32'(1 << exp_g));
    @(negedge clk);
    check({tag, "_push"},  32'(tx_push),  32'd1);
    check({tag, "_wdata"}, 32'(tx_wdata), 32'(exp_d));
    check({tag, "_grant"}, 32'(grant_id), 32'(exp_g));
    req_data = ~d;  // late change must not reach tx_wdata
    #1;
    @(negedge clk);
    check({tag, "_pushfall"}, 32'(tx_push),  32'd0);
    check({tag, "_hold"},     32'(tx_wdata), 32'(exp_d));
  endtask

  typedef struct {
    bit          do_rst;
    logic [3:0]  valid;
    logic [15:0] data;
    int          exp_g;
    logic [3:0]  exp_d;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int          last;
    int          g;
    int          n;
    int          n_push;
    bit          any_ready;
    bit          bad_wd;
    bit          prev_push;
    logic [3:0]  v;
    logic [15:0] d;

    vecs[0]  = '{1'b1, 4'b0100, 16'h0500, 2, 4'h5};  // single requester
    vecs[1]  = '{1'b1, 4'b1111, 16'h4321, 0, 4'h1};  // fairness from reset
    vecs[2]  = '{1'b0, 4'b1111, 16'h4321, 1, 4'h2};
    vecs[3]  = '{1'b0, 4'b1111, 16'h4321, 2, 4'h3};
    vecs[4]  = '{1'b0, 4'b1111, 16'h4321, 3, 4'h4};
    vecs[5]  = '{1'b0, 4'b1111, 16'h4321, 0, 4'h1};
    vecs[6]  = '{1'b0, 4'b0010, 16'h0080, 1, 4'h8};  // -8 passes through
    vecs[7]  = '{1'b0, 4'b1001, 16'h7006, 3, 4'h7};
    vecs[8]  = '{1'b0, 4'b1001, 16'h7006, 0, 4'h6};
    vecs[9]  = '{1'b0, 4'b1100, 16'hF900, 2, 4'h9};
    vecs[10] = '{1'b0, 4'b1100, 16'hF900, 3, 4'hF};

    // Reset state, with enable and all valids already high.
    rst = 1'b1; enable = 1'b1; req_valid = 4'b1111; req_data = 16'h4321;
    @(negedge clk); @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_push",  32'(tx_push),   32'd0);
    check("rst_clear", 32'(tx_clear),  32'd0);
    check("rst_wdata", 32'(tx_wdata),  32'd0);
    check("rst_grant", 32'(grant_id),  32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_tmo",   32'(tmo_err),   32'd0);

    // Table of directed grants.
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].do_rst) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      serve(vecs[i].valid, vecs[i].data, vecs[i].exp_g, vecs[i].exp_d,
            $sformatf("vec%0d", i));
    end

    // Randomized patterns against the reference rule.
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    last = NCH - 1;
    for (int i = 0; i < 40; i++) begin
      v = 4'($urandom_range(1, 15));
      d = 16'($urandom);
      g = rr_pick(last, v);
      serve(v, d, g, 4'(d >> (4 * g)), $sformatf("rnd%0d", i));
      last = g;
    end

    // Reset while tx_push is high; next grant must go to requester 0.
    req_valid = 4'b0100; req_data = 16'h0600;
    #1;
    n = 0;
    while (!(|req_ready) && n < 64) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("mid_push_up", 32'(tx_push), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_push",  32'(tx_push),   32'd0);
    check("mid_rst_busy",  32'(busy),      32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    check("mid_rst_wdata", 32'(tx_wdata),  32'd0);
    check("mid_rst_grant", 32'(grant_id),  32'd0);
    rst = 1'b0;
    serve(4'b1111, 16'h4321, 0, 4'h1, "post_rst");

    // enable dropped in DRAIN: frame completes, then IDLE.
    serve(4'b0001, 16'h0003, 0, 4'h3, "drain");
    enable = 1'b0; req_valid = 4'b0000;
    #1;
    check("drain_busy", 32'(busy), 32'd1);
    n = 0; n_push = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      if (tx_push) n_push++;
      n++;
    end
    check("drain_idle",   32'(busy),     32'd0);
    check("drain_empty",  32'(tx_empty), 32'd1);
    check("drain_nopush", 32'(n_push),   32'd0);

    // Idle fill (or its absence) with enable high and no valids.
    enable = 1'b1;
    n_push = 0; any_ready = 1'b0; bad_wd = 1'b0; prev_push = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx_push && !prev_push) n_push++;
      if (tx_push && tx_wdata != 4'h0) bad_wd = 1'b1;
      if (|req_ready) any_ready = 1'b1;
      prev_push = tx_push;
    end
    check("fill_pushes", 32'(n_push > 0), 32'(FILL_EXP));
    check("fill_ready",  32'(any_ready),  32'd0);
    check("fill_wdata",  32'(bad_wd),     32'd0);
    check("fill_grant",  32'(grant_id),   32'd0);

    // Timeout on the TMO=8 instance: empty never drops after push.
    rst = 1'b1; enable = 1'b1; req_valid = 4'b0001; req_data = 16'h000A;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n = 0;
    while (!(|t2_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("tmo_ready", 32'(t2_ready), 32'd1);
    @(negedge clk);
    n = 0;
    while (t2_push && n < 300) begin
      n++;
      @(negedge clk);
    end
    check("tmo_push_len", 32'(n),          32'd8);
    check("tmo_clear",    32'(t2_clear),   32'd1);
    check("tmo_err_set",  32'(t2_tmo_err), 32'd1);
    check("tmo_busy",     32'(t2_busy),    32'd1);
    check("tmo_wdata",    32'(t2_wdata),   32'hA);
    check("tmo_grant",    32'(t2_grant),   32'd0);
    @(negedge clk);
    check("tmo_clear_1cyc", 32'(t2_clear),   32'd0);
    check("tmo_idle",       32'(t2_busy),    32'd0);
    check("tmo_sticky",     32'(t2_tmo_err), 32'd1);
    enable = 1'b0;
    @(negedge clk);
    check("tmo_err_cleared", 32'(t2_tmo_err), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
